// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register family.
// de_ctrl_t is the decode/execute control bundle carried by the D/E instance.
package pipe_pkg;

    typedef struct packed {
        logic       wbs;
        logic       mm;
        logic [2:0] alu_op;
        logic       wm;
        logic       am;
        logic       ni;
        logic       wce;
        logic       wme1;
        logic       wme2;
        logic [1:0] alu_mux;
    } de_ctrl_t;

    localparam int unsigned DE_CTRL_W  = $bits(de_ctrl_t);
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned NSRC_DEF   = 2;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid/ready bundle of a pipeline stage register.
// The stage itself uses the slave modport; the producer/consumer side uses master.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DE_CTRL_W,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NSRC   = NSRC_DEF
);

    logic                     in_valid;
    logic                     in_ready;
    logic [CTRL_W-1:0]        in_ctrl;
    logic [NSRC*DATA_W-1:0]   in_src;
    logic                     out_valid;
    logic                     out_ready;
    logic [CTRL_W-1:0]        out_ctrl;
    logic [NSRC*DATA_W-1:0]   out_src;

    modport master (
        output in_valid, in_ctrl, in_src, out_ready,
        input  in_ready, out_valid, out_ctrl, out_src
    );

    modport slave (
        input  in_valid, in_ctrl, in_src, out_ready,
        output in_ready, out_valid, out_ctrl, out_src
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Single skid entry: holds one beat behind the main register of a stage.
// clr_i empties the entry without touching its data.
module pipe_skid_buf #(
    parameter int unsigned CTRL_W = 13,
    parameter int unsigned SRC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              pop_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [SRC_W-1:0]  src_i,
    output logic              full_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [SRC_W-1:0]  src_o
);

    logic              full_q, full_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [SRC_W-1:0]  src_q, src_d;

    always_comb begin
        full_d = full_q;
        ctrl_d = ctrl_q;
        src_d  = src_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            ctrl_d = ctrl_i;
            src_d  = src_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            ctrl_q <= '0;
            src_q  <= '0;
        end else begin
            full_q <= full_d;
            ctrl_q <= ctrl_d;
            src_q  <= src_d;
        end
    end

    assign full_o = full_q;
    assign ctrl_o = ctrl_q;
    assign src_o  = src_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and saturating stall count.
// Define PIPE_STAGE_SKID_EN for a two-entry stage with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W  = DE_CTRL_W,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned NSRC    = NSRC_DEF,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_stage_reg_if.slave    bus,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int unsigned SRC_W = NSRC * DATA_W;

    logic               valid_q, valid_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               in_ready;
    logic               xfer_in;
    logic               xfer_out;

    assign xfer_in  = bus.in_valid && in_ready;
    assign xfer_out = valid_q && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_full;
    logic              skid_load;
    logic              skid_pop;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [SRC_W-1:0]  skid_src;

    // Ready depends only on registered state, breaking the out_ready -> in_ready path.
    assign in_ready = !rst && !skid_full;

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .SRC_W  (SRC_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (flush),
        .load_i (skid_load),
        .pop_i  (skid_pop),
        .ctrl_i (bus.in_ctrl),
        .src_i  (bus.in_src),
        .full_o (skid_full),
        .ctrl_o (skid_ctrl),
        .src_o  (skid_src)
    );

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        src_d     = src_q;
        skid_load = 1'b0;
        skid_pop  = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (xfer_out) begin
            if (skid_full) begin
                ctrl_d   = skid_ctrl;
                src_d    = skid_src;
                skid_pop = 1'b1;
            end else if (xfer_in) begin
                ctrl_d = bus.in_ctrl;
                src_d  = bus.in_src;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end else if (xfer_in) begin
            if (valid_q) begin
                skid_load = 1'b1;
            end else begin
                valid_d = 1'b1;
                ctrl_d  = bus.in_ctrl;
                src_d   = bus.in_src;
            end
        end
    end
`else
    assign in_ready = !rst && (!valid_q || bus.out_ready);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        src_d   = src_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (xfer_in) begin
            valid_d = 1'b1;
            ctrl_d  = bus.in_ctrl;
            src_d   = bus.in_src;
        end else if (xfer_out) begin
            // Zeroed control keeps write enables from leaking into the next stage.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end
`endif

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !bus.out_ready && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            src_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            src_q   <= src_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_ctrl  = ctrl_q;
    assign bus.out_src   = src_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a beat-queue model checked every cycle,
// plus literal expectations at key points. Honours PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int unsigned CW  = 13;
    localparam int unsigned DW  = 16;
    localparam int unsigned NS  = 2;
    localparam int unsigned SW  = NS * DW;
    localparam int unsigned STW = 4;
    localparam int          SAT = (1 << STW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int          CAP = 2;
`else
    localparam int          CAP = 1;
`endif

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           flush = 1'b0;
    logic [STW-1:0] stall_cnt;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .NSRC(NS)) bus ();

    pipe_stage_reg #(
        .CTRL_W  (CW),
        .DATA_W  (DW),
        .NSRC    (NS),
        .STALL_W (STW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [SW-1:0] src;
    } beat_t;

    beat_t         mq[$];
    beat_t         m_beat;
    logic [SW-1:0] m_src   = '0;
    int            m_stall = 0;
    bit            m_acc;
    bit            m_pop;
    bit            started = 1'b0;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // A stage is a FIFO of capacity CAP; base mode may also accept while the head leaves.
    function automatic bit model_ready();
        if (rst) return 1'b0;
        if (CAP == 2) return mq.size() < 2;
        return mq.size() == 0 || bus.out_ready;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            mq.delete();
            m_src   = '0;
            m_stall = 0;
        end else begin
            if (mq.size() > 0 && !bus.out_ready && m_stall < SAT) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                m_acc = bus.in_valid && model_ready();
                m_pop = mq.size() > 0 && bus.out_ready;
                if (m_pop) void'(mq.pop_front());
                if (m_acc) begin
                    m_beat.ctrl = bus.in_ctrl;
                    m_beat.src  = bus.in_src;
                    mq.push_back(m_beat);
                end
                if (mq.size() > 0) m_src = mq[0].src;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
            check("m_out_ctrl", 64'(bus.out_ctrl), 64'((mq.size() > 0) ? mq[0].ctrl : '0));
            check("m_out_src", 64'(bus.out_src), 64'(m_src));
            check("m_in_ready", 64'(bus.in_ready), 64'(model_ready()));
            check("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
        end
    end

    task automatic set_in(input logic v, input logic [CW-1:0] c, input logic [SW-1:0] s);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_src   = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1'b1, 13'h1FFF, '1);
        bus.out_ready = 1'b0;

        // Reset held with a valid beat presented
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", 64'(bus.out_valid), 64'h0);
            check("rst_out_ctrl", 64'(bus.out_ctrl), 64'h0);
            check("rst_out_src", 64'(bus.out_src), 64'h0);
            check("rst_in_ready", 64'(bus.in_ready), 64'h0);
        end
        rst = 1'b0;
        set_in(1'b0, '0, '0);
        tick();
        check("rel_out_valid", 64'(bus.out_valid), 64'h0);
        check("rel_stall", 64'(stall_cnt), 64'h0);

        // Streaming
        bus.out_ready = 1'b1;
        set_in(1'b1, 13'h011, 32'h0001_0002);
        tick();
        check("s1_valid", 64'(bus.out_valid), 64'h1);
        check("s1_src", 64'(bus.out_src), 64'h0001_0002);
        set_in(1'b1, 13'h022, 32'h0003_0004);
        tick();
        check("s2_valid", 64'(bus.out_valid), 64'h1);
        check("s2_ctrl", 64'(bus.out_ctrl), 64'h022);
        check("s2_src", 64'(bus.out_src), 64'h0003_0004);
        set_in(1'b0, '0, '0);
        tick();
        check("s3_valid", 64'(bus.out_valid), 64'h0);
        check("s3_ctrl", 64'(bus.out_ctrl), 64'h0);
        check("s3_src_hold", 64'(bus.out_src), 64'h0003_0004);
        check("s3_stall", 64'(stall_cnt), 64'h0);

        // Back-pressure for 5 cycles with a second beat waiting
        bus.out_ready = 1'b0;
        set_in(1'b1, 13'h0B1, 32'hAAAA_5555);
        tick();
        set_in(1'b1, 13'h0C2, 32'hBBBB_6666);
        repeat (5) tick();
        check("bp_stall", 64'(stall_cnt), 64'h5);
        check("bp_ctrl", 64'(bus.out_ctrl), 64'h0B1);
        check("bp_src", 64'(bus.out_src), 64'hAAAA_5555);
        check("bp_in_ready", 64'(bus.in_ready), 64'h0);
        set_in(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        check("bp_drain2_valid", 64'(bus.out_valid), 64'h1);
        check("bp_drain2_ctrl", 64'(bus.out_ctrl), 64'h0C2);
        check("bp_drain2_src", 64'(bus.out_src), 64'hBBBB_6666);
        check("bp_drain2_ready", 64'(bus.in_ready), 64'h1);
        tick();
`endif
        check("bp_empty_valid", 64'(bus.out_valid), 64'h0);
        check("bp_empty_ctrl", 64'(bus.out_ctrl), 64'h0);

        // Flush while stalled, with a new beat offered in the same cycle
        bus.out_ready = 1'b0;
        set_in(1'b1, 13'h155, 32'h1234_5678);
        tick();
        check("fl_loaded", 64'(bus.out_valid), 64'h1);
        flush = 1'b1;
        set_in(1'b1, 13'h0EE, 32'hDEAD_BEEF);
        tick();
        flush = 1'b0;
        set_in(1'b0, '0, '0);
        check("fl_valid", 64'(bus.out_valid), 64'h0);
        check("fl_ctrl", 64'(bus.out_ctrl), 64'h0);
        check("fl_src_hold", 64'(bus.out_src), 64'h1234_5678);
        check("fl_stall", 64'(stall_cnt), 64'h6);
        tick();
        check("fl_absent", 64'(bus.out_valid), 64'h0);

        // Saturation, then reset mid-stall with flush and a beat offered
        set_in(1'b1, 13'h0F0, 32'h0F0F_F0F0);
        tick();
        set_in(1'b0, '0, '0);
        repeat (20) tick();
        check("sat_stall", 64'(stall_cnt), 64'hF);
        rst   = 1'b1;
        flush = 1'b1;
        set_in(1'b1, 13'h1AA, 32'h5A5A_A5A5);
        tick();
        check("rst_mid_stall", 64'(stall_cnt), 64'h0);
        check("rst_mid_valid", 64'(bus.out_valid), 64'h0);
        check("rst_mid_src", 64'(bus.out_src), 64'h0);
        rst   = 1'b0;
        flush = 1'b0;
        set_in(1'b0, '0, '0);
        tick();

        // Simultaneous load and unload
        bus.out_ready = 1'b1;
        set_in(1'b1, 13'h033, 32'h1111_2222);
        tick();
        set_in(1'b1, 13'h0A5, 32'h3333_4444);
        tick();
        check("sim_ctrl", 64'(bus.out_ctrl), 64'h0A5);
        check("sim_valid", 64'(bus.out_valid), 64'h1);
        check("sim_src", 64'(bus.out_src), 64'h3333_4444);
        set_in(1'b0, '0, '0);
        tick();
        check("sim_drained", 64'(bus.out_valid), 64'h0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
